// File: rtl/weight_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : weight_stream_loader
// Purpose  : Loads TOTAL_WEIGHTS consecutive W-bit words from a read-only
//            BRAM port, starting at a runtime base address, into a flat
//            parallel buffer. With STREAM_EN=1 every word is also presented,
//            in order, on a valid/ready stream through a small skid FIFO.
//            Re-triggerable once a load has completed.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, base_addr  - one-cycle load request and first address
//            bram_en/addr/dout - BRAM read port (RD_LATENCY cycle reads)
//            data_out          - word k at [k*W +: W]
//            wt_valid/data/ready - weight stream (tied off when STREAM_EN=0)
//            busy, done        - load in progress / load complete (level)
// Revision : 1.0 - initial release
// ============================================================================
module weight_stream_loader #(
  parameter int IN_SIZE       = 1152,
  parameter int OUT_SIZE      = 8,
  parameter int W             = 8,
  parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
  parameter int ADDR_WIDTH    = 18,
  parameter int RD_LATENCY    = 2,
  parameter int STREAM_EN     = 1,
  parameter int FIFO_DEPTH    = RD_LATENCY + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         bram_en,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  input  logic [W-1:0]                 bram_dout,
  output logic [TOTAL_WEIGHTS*W-1:0]   data_out,
  output logic                         wt_valid,
  output logic [W-1:0]                 wt_data,
  input  logic                         wt_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int c_CW = $clog2(TOTAL_WEIGHTS + 1);
  localparam int c_IW = (TOTAL_WEIGHTS > 1) ? $clog2(TOTAL_WEIGHTS) : 1;
  localparam int c_FW = $clog2(FIFO_DEPTH + 1);
  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CW-1:0] c_TOTAL = c_CW'(TOTAL_WEIGHTS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  logic [c_CW-1:0]                 r_issued;
  logic [c_CW-1:0]                 r_returned;
  logic                            r_bram_en;
  logic [ADDR_WIDTH-1:0]           r_bram_addr;
  logic [RD_LATENCY-1:0]           r_vld_sr;
  logic                            r_busy;
  logic                            r_done;
  logic [TOTAL_WEIGHTS-1:0][W-1:0] r_words;

  logic                            w_ret;
  logic [c_CW-1:0]                 w_issued_n;
  logic [c_CW-1:0]                 w_returned_n;
  logic [c_CW-1:0]                 w_inflight_n;
  logic [c_IW-1:0]                 w_wr_idx;
  logic [c_FW-1:0]                 w_fifo_cnt_n;
  logic                            w_credit_ok;
  logic                            w_issue_n;

  function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(FIFO_DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  // A read returns exactly RD_LATENCY cycles after its bram_en cycle.
  assign w_ret        = r_vld_sr[RD_LATENCY-1];
  assign w_issued_n   = r_issued + c_CW'(r_bram_en);
  assign w_returned_n = r_returned + c_CW'(w_ret);
  assign w_inflight_n = w_issued_n - w_returned_n;
  // Returned count is always below TOTAL_WEIGHTS when a word lands, so its
  // low bits address the buffer directly.
  assign w_wr_idx     = r_returned[c_IW-1:0];

  // bram_en is registered, so the credit test is evaluated on next-cycle
  // occupancy: every read that could be in flight or queued must fit in
  // the FIFO even if the consumer stops accepting.
  assign w_credit_ok = (STREAM_EN == 0) ||
                       ((32'(w_inflight_n) + 32'(w_fifo_cnt_n)) < 32'(FIFO_DEPTH));
  assign w_issue_n   = (w_issued_n != c_TOTAL) && w_credit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_issued    <= '0;
      r_returned  <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_vld_sr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_words     <= '0;
    end else begin
      r_vld_sr    <= (r_vld_sr << 1) | RD_LATENCY'(r_bram_en);
      r_issued    <= w_issued_n;
      // bram_addr always points at the next word to read; it wraps freely.
      r_bram_addr <= r_bram_addr + ADDR_WIDTH'(r_bram_en);
      if (w_ret) begin
        r_words[w_wr_idx] <= bram_dout;
        r_returned        <= w_returned_n;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_ISSUE;
            r_issued    <= '0;
            r_returned  <= '0;
            r_bram_en   <= 1'b1;
            r_bram_addr <= base_addr;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_bram_en <= w_issue_n;
          if (w_issued_n == c_TOTAL) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((w_returned_n == c_TOTAL) && (w_fifo_cnt_n == '0)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    if (STREAM_EN != 0) begin : g_stream
      logic [W-1:0]      r_mem [FIFO_DEPTH];
      logic [c_PW-1:0]   r_wr_ptr;
      logic [c_PW-1:0]   r_rd_ptr;
      logic [c_FW-1:0]   r_count;
      logic              w_push;
      logic              w_pop;

      assign w_push       = w_ret;
      assign w_pop        = (r_count != '0) && wt_ready;
      assign w_fifo_cnt_n = r_count + c_FW'(w_push) - c_FW'(w_pop);
      assign wt_valid     = (r_count != '0);
      // The head entry is never overwritten while occupied, so wt_data
      // holds steady under backpressure.
      assign wt_data      = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
          end
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wr_ptr] <= bram_dout;
            r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
          end
          if (w_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
          end
          r_count <= w_fifo_cnt_n;
        end
      end

      // The credit rule makes a push into a full FIFO impossible.
      always_ff @(posedge clk) begin
        if (!rst) begin
          assert (!(w_push && !w_pop && (r_count == c_FW'(FIFO_DEPTH))));
        end
      end
    end else begin : g_no_stream
      logic w_unused_ready;
      assign w_unused_ready = wt_ready;
      assign w_fifo_cnt_n   = '0;
      assign wt_valid       = 1'b0;
      assign wt_data        = '0;
    end
  endgenerate

  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign data_out  = r_words;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire
